// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter: round-robin, message-locked sharing of one UART byte port
// between N_REQ byte-stream requesters, with a level start / busy handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; the next valid requester after rr_ptr wins a byte
// ST_SEND  | uart_tx_start high, waiting for a fresh busy rise
// ST_DRAIN | start dropped, waiting for busy to fall
// ST_HOLD  | owner locked between bytes; the hold timer guards against stalls
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         uart_tx_d,
  output logic               uart_tx_start,
  input  logic               uart_tx_busy,
  output logic               timeout_pulse
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(HOLD_MAX - 1);
  localparam logic [PW-1:0] PTR_RST  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]        tx_d_q, tx_d_d;
  logic              last_q, last_d;
  logic              start_q, start_d;
  logic              pulse_q, pulse_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              armed_q, armed_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;

  // Index base+k modulo N_REQ, for k in 1..N_REQ.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PW'(sum);
  endfunction

  function automatic logic [7:0] byte_of(input logic [PW-1:0] idx);
    return req_data[8*int'(idx) +: 8];
  endfunction

  // Round-robin search: first valid requester after rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, ownership, byte latch and hold-timer logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    tx_d_d    = tx_d_q;
    last_d    = last_q;
    timer_d   = timer_q;
    pulse_d   = 1'b0;
    req_ready = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          grant_d            = '0;
          grant_d[win_idx]   = 1'b1;
          owner_d            = win_idx;
          tx_d_d             = byte_of(win_idx);
          last_d             = req_last[win_idx];
          state_d            = ST_SEND;
        end
      end

      ST_SEND: begin
        // Only a busy rise seen after busy was low counts; a stale busy
        // left over from an abandoned byte must not complete this one.
        if (uart_tx_busy && armed_q) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!uart_tx_busy) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = owner_q;
            state_d  = ST_IDLE;
          end else begin
            timer_d = '0;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        req_ready[owner_q] = 1'b1;
        if (req_valid[owner_q]) begin
          // A transfer on the expiry edge takes priority over revocation.
          tx_d_d  = byte_of(owner_q);
          last_d  = req_last[owner_q];
          state_d = ST_SEND;
        end else if (timer_q == TMR_LAST) begin
          pulse_d  = 1'b1;
          grant_d  = '0;
          rr_ptr_d = owner_q;
          state_d  = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    start_d = (state_d == ST_SEND);
    armed_d = uart_tx_busy ? (armed_q && (state_q != ST_SEND)) : 1'b1;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= PTR_RST;
      tx_d_q   <= 8'h00;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      pulse_q  <= 1'b0;
      timer_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      tx_d_q   <= tx_d_d;
      last_q   <= last_d;
      start_q  <= start_d;
      pulse_q  <= pulse_d;
      timer_q  <= timer_d;
      armed_q  <= armed_d;
    end
  end

  assign grant         = grant_q;
  assign uart_tx_d     = tx_d_q;
  assign uart_tx_start = start_q;
  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: requester queues, a UART busy model and a
// scoreboard of {grant, byte} in expected service order.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int HMAX     = 8;
  localparam int BUSY_LEN = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     uart_tx_d;
  logic           uart_tx_start;
  logic           uart_tx_busy;
  logic           timeout_pulse;

  uart_tx_arbiter #(.N_REQ(N), .HOLD_MAX(HMAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .uart_tx_d     (uart_tx_d),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .timeout_pulse (timeout_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] sb [$];
  logic [8:0]  rq [N][$];

  int rise_dly = 3;
  int m_cnt    = 0;
  bit m_pend   = 1'b0;

  bit mon_en   = 1'b1;
  bit lock_mon = 1'b0;
  int viol_start = 0, viol_txd = 0, viol_grant = 0, viol_lock = 0;
  int n_pulse = 0, n_start_rise = 0, run = 0, min_run = 1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int r);
    return 4'b0001 << r;
  endfunction

  task automatic load(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    sb.push_back({onehot(r), d});
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      done = (sb.size() == 0) && rq_empty() && (req_valid == '0) && (grant == '0) &&
             !uart_tx_start && !uart_tx_busy && !m_pend;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: not idle after %0d cycles, %0d bytes outstanding", name, budget, sb.size());
      sb.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
    end
  endtask

  // Requester driver: pops a byte once accepted, presents the next one.
  initial begin : driver
    logic [N-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready & {N{rst_n}};
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if (rq[i].size() != 0) rq[i].delete(0);
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && rq[i].size() != 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = rq[i][0][7:0];
          req_last[i]         = rq[i][0][8];
        end
      end
    end
  end

  // UART model: busy rises rise_dly cycles after start is seen, lasts BUSY_LEN.
  initial begin : uart_model
    logic [11:0] e;
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (uart_tx_busy) begin
        m_cnt--;
        if (m_cnt <= 0) uart_tx_busy = 1'b0;
      end else if (m_pend) begin
        m_cnt--;
        if (m_cnt <= 0) begin
          uart_tx_busy = 1'b1;
          m_pend       = 1'b0;
          m_cnt        = BUSY_LEN;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL uart_byte: unexpected byte 0x%0h grant %b, none expected", uart_tx_d, grant);
          end else begin
            e = sb.pop_front();
            check("uart_byte{grant,data}", {20'd0, grant, uart_tx_d}, {20'd0, e});
          end
        end
      end else if (uart_tx_start) begin
        m_pend = 1'b1;
        m_cnt  = rise_dly;
      end
    end
  end

  // Protocol monitors sampled on the falling edge.
  initial begin : monitor
    logic       p_start, p_busy, p_rst;
    logic [7:0] p_txd;
    p_start = 1'b0; p_busy = 1'b0; p_rst = 1'b0; p_txd = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && p_rst) begin
        if (p_start && !uart_tx_start && !p_busy) viol_start++;
        if ((p_start || p_busy) && (uart_tx_start || uart_tx_busy) && (uart_tx_d != p_txd)) viol_txd++;
      end
      if (!$onehot0(grant)) viol_grant++;
      if (lock_mon && grant == 4'b0100 && req_ready[0]) viol_lock++;
      if (timeout_pulse) n_pulse++;
      if (uart_tx_start && !p_start) n_start_rise++;
      if (uart_tx_start) run++;
      else if (p_start) begin
        if (run < min_run) min_run = run;
        run = 0;
      end
      p_start = uart_tx_start; p_busy = uart_tx_busy; p_rst = rst_n; p_txd = uart_tx_d;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] ready;
  } rdy_vec_t;

  // m1: requesters with one message, m2: those with a second message.
  // order: service order, one requester per nibble, lowest nibble first.
  typedef struct packed {
    logic [3:0]  m1;
    logic [3:0]  m2;
    logic [31:0] order;
    logic [3:0]  n_order;
  } rr_vec_t;

  initial begin : test
    rdy_vec_t rdy_tab [7];
    rr_vec_t  rr_tab  [7];
    int       mcnt [N];
    int       r, gap, sr0, pc0;
    bit       found;

    rdy_tab[0] = '{valid: 4'b0000, ready: 4'b0000};
    rdy_tab[1] = '{valid: 4'b0001, ready: 4'b0001};
    rdy_tab[2] = '{valid: 4'b1000, ready: 4'b1000};
    rdy_tab[3] = '{valid: 4'b0110, ready: 4'b0010};
    rdy_tab[4] = '{valid: 4'b1100, ready: 4'b0100};
    rdy_tab[5] = '{valid: 4'b1111, ready: 4'b0001};
    rdy_tab[6] = '{valid: 4'b1010, ready: 4'b0010};

    rr_tab[0] = '{m1: 4'b1111, m2: 4'b0000, order: 32'h0000_3210, n_order: 4'd4};
    rr_tab[1] = '{m1: 4'b1010, m2: 4'b1010, order: 32'h0000_3131, n_order: 4'd4};
    rr_tab[2] = '{m1: 4'b0101, m2: 4'b0000, order: 32'h0000_0020, n_order: 4'd2};
    rr_tab[3] = '{m1: 4'b0111, m2: 4'b0000, order: 32'h0000_0210, n_order: 4'd3};
    rr_tab[4] = '{m1: 4'b1010, m2: 4'b0000, order: 32'h0000_0013, n_order: 4'd2};
    rr_tab[5] = '{m1: 4'b1001, m2: 4'b0000, order: 32'h0000_0003, n_order: 4'd2};
    rr_tab[6] = '{m1: 4'b1110, m2: 4'b0000, order: 32'h0000_0321, n_order: 4'd3};

    // Reset values and the reset-priority arbitration, applied while in reset.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_start", {31'd0, uart_tx_start}, 32'd0);
    check("rst_tx_d", {24'd0, uart_tx_d}, 32'd0);
    check("rst_timeout", {31'd0, timeout_pulse}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = rdy_tab[i].valid;
      #1;
      check($sformatf("rst_ready[v=%b]", rdy_tab[i].valid), {28'd0, req_ready}, {28'd0, rdy_tab[i].ready});
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {28'd0, req_ready}, 32'd0);
    check("idle_grant", {28'd0, grant}, 32'd0);

    // Round-robin table.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++) begin
        mcnt[i] = 0;
        if (rr_tab[v].m1[i]) load(i, 8'(8'h10 + i), 1'b1);
      end
      for (int i = 0; i < N; i++)
        if (rr_tab[v].m2[i]) load(i, 8'(8'h20 + i), 1'b1);
      for (int k = 0; k < int'(rr_tab[v].n_order); k++) begin
        r = int'(rr_tab[v].order[4*k +: 4]);
        expect_byte(r, 8'(16 * (mcnt[r] + 1) + r));
        mcnt[r]++;
      end
      wait_idle($sformatf("rr_vec%0d", v), 400);
    end

    // Single three-byte message from req0.
    sr0 = n_start_rise;
    load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
    expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h43);
    wait_idle("single_msg", 400);
    check("single_start_count", n_start_rise - sr0, 32'd3);
    check("single_grant_after", {28'd0, grant}, 32'd0);

    // Lock: req2 owns a 2-byte message, req0 waits.
    lock_mon = 1'b1;
    load(2, 8'h21, 1'b0); load(2, 8'h22, 1'b1);
    expect_byte(2, 8'h21); expect_byte(2, 8'h22); expect_byte(0, 8'h05);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      found = (grant == 4'b0100);
    end
    check("lock_grant2", {31'd0, found}, 32'd1);
    load(0, 8'h05, 1'b1);
    wait_idle("lock", 400);
    lock_mon = 1'b0;
    check("lock_ready0_while_owned", viol_lock, 32'd0);

    // Timeout: req1 stalls after a non-last byte; req2 waits.
    load(1, 8'h31, 1'b0); expect_byte(1, 8'h31); expect_byte(2, 8'h32);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      found = grant[1] && req_ready[1];
    end
    check("timeout_hold_entry", {31'd0, found}, 32'd1);
    load(2, 8'h32, 1'b1);
    gap = -1;
    for (int n = 1; n <= 20 && gap < 0; n++) begin
      @(negedge clk);
      if (timeout_pulse) gap = n;
    end
    check("timeout_gap", gap, 32'd8);
    check("timeout_grant_cleared", {28'd0, grant}, 32'd0);
    @(negedge clk);
    check("timeout_pulse_width", {31'd0, timeout_pulse}, 32'd0);
    check("timeout_next_grant", {28'd0, grant}, 32'd4);
    wait_idle("timeout", 400);

    // Owner byte arrives exactly on the expiry edge: accepted, no pulse.
    pc0 = n_pulse;
    load(1, 8'h33, 1'b0); expect_byte(1, 8'h33); expect_byte(1, 8'h34);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      found = grant[1] && req_ready[1];
    end
    check("expiry_hold_entry", {31'd0, found}, 32'd1);
    repeat (6) @(negedge clk);
    load(1, 8'h34, 1'b1);
    wait_idle("expiry_transfer", 400);
    check("expiry_no_pulse", n_pulse - pc0, 32'd0);

    // Slow busy rise: start must stay up the whole time.
    rise_dly = 50;
    min_run  = 1000;
    load(3, 8'hA1, 1'b0); load(3, 8'hA2, 1'b1);
    expect_byte(3, 8'hA1); expect_byte(3, 8'hA2);
    wait_idle("slow_busy", 600);
    check("slow_start_len_50_55", {31'd0, (min_run >= 50 && min_run <= 55)}, 32'd1);
    rise_dly = 3;

    // Reset during DRAIN; the next arbitration restarts at req0.
    mon_en = 1'b0;
    load(2, 8'h61, 1'b1); expect_byte(2, 8'h61);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      found = grant[2] && !uart_tx_start && uart_tx_busy;
    end
    check("reset_drain_reached", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_mid_start", {31'd0, uart_tx_start}, 32'd0);
    check("reset_mid_grant", {28'd0, grant}, 32'd0);
    check("reset_mid_timeout", {31'd0, timeout_pulse}, 32'd0);
    load(0, 8'h70, 1'b1); load(3, 8'h73, 1'b1);
    expect_byte(0, 8'h70); expect_byte(3, 8'h73);
    wait_idle("reset_recover", 600);
    mon_en = 1'b1;

    check("start_dropped_without_busy", viol_start, 32'd0);
    check("tx_d_changed_while_busy", viol_txd, 32'd0);
    check("grant_not_onehot", viol_grant, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `N_REQ` byte-stream requesters, one whole message at a time. Arbitration is round-robin: a requester that wins keeps the transmitter until it hands over a byte marked `last`, or until it stalls longer than `HOLD_MAX` cycles. The block drives the UART byte port with a level start / busy handshake, so it tolerates the UART running on its slower divided clock. It sits between the application byte sources (echo path, status reporter, debug dump) and the `uart` instance in `top`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `HOLD_MAX`, 4096: idle cycles a locked owner may stall before its lock is revoked (≥1).

Ports:
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  N_REQ: requester i has a byte on its slice of `req_data`.
- `req_data`  in  8*N_REQ: byte of requester i is bits [8i+7:8i].
- `req_last`  in  N_REQ: the offered byte ends requester i's message.
- `req_ready`  out  N_REQ: combinational accept; a byte transfers on an edge where `req_valid[i] & req_ready[i]`.
- `grant`  out  N_REQ: one-hot current owner; all zero when there is no owner.
- `uart_tx_d`  out  8: byte to the UART, held stable while `uart_tx_start` or `uart_tx_busy` is high.
- `uart_tx_start`  out  1: level request to the UART; high until `uart_tx_busy` is seen high.
- `uart_tx_busy`  in  1: UART is shifting a byte.
- `timeout_pulse`  out  1: one-cycle pulse when a stalled owner's lock is revoked.

## Operation
States:
- **IDLE** (no owner)
  - The winner is the first `i` with `req_valid[i]` set, searching from `rr_ptr+1` upward with wrap.
  - `req_ready` is one-hot on the winner only.
  - On transfer: latch `req_data` into `uart_tx_d` and `req_last` into `last_q`; set `grant` to the winner; go to SEND.
- **SEND**
  - `uart_tx_start` = 1.
  - When `uart_tx_busy` = 1 is sampled, go to DRAIN.
  - `busy` = 0 in this state never counts as completion.
- **DRAIN**
  - `uart_tx_start` = 0.
  - When `uart_tx_busy` = 0 is sampled:
    - if `last_q` is set: clear `grant`, set `rr_ptr` to the owner index, go to IDLE;
    - otherwise clear the hold timer and go to HOLD.
- **HOLD** (owner locked)
  - `req_ready[owner]` = 1; all other bits are 0.
  - On owner transfer: latch the byte and `last`, go to SEND.
  - Otherwise increment the hold timer.
  - When the timer reaches `HOLD_MAX-1` with no transfer: pulse `timeout_pulse`, clear `grant`, set `rr_ptr` to the owner, go to IDLE.
  - A transfer on the same edge as the timer expiring wins; no timeout is raised.

Rules:
- `req_ready` is 0 in SEND and DRAIN.
- Valid bytes from non-owners are ignored (not accepted) and are never dropped.
- The hold timer is `clog2(HOLD_MAX)` bits wide and saturates; it never wraps.
- Reset values:
  - `state` = IDLE
  - `grant` = 0
  - `uart_tx_start` = 0
  - `uart_tx_d` = 0
  - `last_q` = 0
  - `timeout_pulse` = 0
  - timer = 0
  - `rr_ptr` = N_REQ-1, so requester 0 has first priority.
- Reset mid-message: all state returns to reset values on the next edge, and the in-flight byte is abandoned.
  - The UART may still finish shifting it.
  - After reset, SEND waits only for a fresh busy rise.

## Timing
- IDLE → SEND: transfer at edge k; `uart_tx_start` and `grant` are high from k+1.
- SEND → DRAIN: `busy` sampled high at edge m; `start` is low from m+1.
- DRAIN exit: `busy` sampled low at edge p; IDLE or HOLD from p+1.
  - In HOLD, the next owner byte can transfer at edge p+1.
  - After a `last` byte, a new arbitration can transfer at edge p+1.
- Per-byte overhead on top of the UART frame time: 2 `clk` cycles plus the UART's busy-rise latency.
- `timeout_pulse` is high for exactly one cycle, the first cycle of IDLE after revocation.

## Test plan
- **Single message.** After reset, req0 sends 0x41, 0x42, 0x43 (last on 0x43) with an ideal UART model (busy rises 3 cycles after start, lasts 20 cycles).
  - Required: three `start` assertions, bytes in order, `grant` = 0001 throughout, `grant` = 0 after the final drain.
- **Round-robin.** req0..req3 all hold single-byte messages (0x10..0x13, last = 1).
  - Required: service order 0, 1, 2, 3.
  - Then with req1 and req3 continuously valid after serving 3: order 1, 3, 1, 3.
- **Lock.** req2 owns a 2-byte message while req0 is valid.
  - Required: req0 is not accepted until req2's last byte has drained; `req_ready[0]` stays 0 meanwhile.
- **Timeout.** `HOLD_MAX` = 8; req1 sends a non-last byte, then drops valid.
  - Required: `timeout_pulse` 8 cycles after entering HOLD, `grant` cleared, waiting req2 granted next.
  - Repeat with req1 valid exactly on the expiry edge: the byte is accepted and there is no pulse.
- **Handshake robustness.** UART busy rise delayed 50 cycles.
  - Required: `start` held the full 50 cycles and `uart_tx_d` stable.
  - Also assert `busy` low during SEND never advances the state.
- **Reset mid-operation.** Drop `rst_n` for 1 cycle during DRAIN.
  - Required: `start`, `grant` and `timeout_pulse` are 0 on the next cycle, and the next arbitration favors req0.
